// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC interrupt gateway: per-source state encoding
// and the mapping between interrupt IDs and source indices (source k <-> ID k+1).
package plic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_CLAIMED = 2'd2
    } gw_state_e;

    // ID 0 is reserved as "no interrupt"; IDs beyond the source count are unused.
    function automatic logic id_valid(input int unsigned id, input int unsigned num_src);
        return (id != 0) && (id <= num_src);
    endfunction

    function automatic int unsigned id_to_idx(input int unsigned id);
        return id - 1;
    endfunction

endpackage

// File: rtl/plic_gw_src.sv
// One interrupt source: 2-flop sync, edge detect, saturating edge counter, IDLE/PEND/CLAIMED FSM.
// Latency: line change to pending_o is 3 edges; strobes act on the next edge; no backpressure.
module plic_gw_src
    import plic_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             edge_det;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    gw_state_e        state;
    gw_state_e        state_nxt;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            prev      <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
            pending_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            sync1     <= irq_i;
            sync2     <= sync1;
            prev      <= sync2;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending_o <= (state_nxt == ST_PEND);
            busy_o    <= (state_nxt == ST_CLAIMED);
        end
    end

    // Mode gating is combinational so a mode change affects detection at once.
    assign edge_det = edge_mode_i && sync2 && !prev;

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!edge_mode_i) begin
                    if (sync2) state_nxt = ST_PEND;
                end else if (edge_det) begin
                    state_nxt = ST_PEND;
                end else if (cnt != '0) begin
                    state_nxt = ST_PEND;
                    cnt_dec   = 1'b1;
                end
            end
            ST_PEND: begin
                cnt_inc = edge_det;
                if (claim_i) state_nxt = ST_CLAIMED;
            end
            ST_CLAIMED: begin
                cnt_inc = edge_det;
                if (complete_i) begin
                    if (edge_mode_i && (cnt != '0)) begin
                        state_nxt = ST_PEND;
                        cnt_dec   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A simultaneous increment and decrement cancel out.
        cnt_nxt = cnt;
        if (!edge_mode_i) begin
            cnt_nxt = '0;
        end else if (cnt_inc && !cnt_dec) begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway: decodes claim/complete IDs to one-hot strobes and runs one gateway per source.
// Latency: 3 edges from a raw line to pending_o; claim/complete act on the next edge; no backpressure.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned CNT_W   = 2
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] edge_mode_i,
    input  logic               claim_i,
    input  logic [ID_W-1:0]    claim_id_i,
    input  logic               complete_i,
    input  logic [ID_W-1:0]    complete_id_i,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] busy_o
);

    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic               claim_ok;
    logic               complete_ok;

    assign claim_ok    = claim_i    && id_valid(32'(claim_id_i), NUM_SRC);
    assign complete_ok = complete_i && id_valid(32'(complete_id_i), NUM_SRC);

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign claim_hit[k]    = claim_ok    && (id_to_idx(32'(claim_id_i))    == 32'(k));
        assign complete_hit[k] = complete_ok && (id_to_idx(32'(complete_id_i)) == 32'(k));

        plic_gw_src #(
            .CNT_W (CNT_W)
        ) u_src (
            .clk_i       (clk_i),
            .resetn_i    (resetn_i),
            .irq_i       (irq_src_i[k]),
            .edge_mode_i (edge_mode_i[k]),
            .claim_i     (claim_hit[k]),
            .complete_i  (complete_hit[k]),
            .pending_o   (pending_o[k]),
            .busy_o      (busy_o[k])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed scenarios with literal expectations plus randomized
// traffic, all cross-checked every cycle against a behavioural model of the gateway rules.
module tb_plic_gateway;

    localparam int NUM_SRC = 5;
    localparam int ID_W    = 3;
    localparam int CNT_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NUM_SRC-1:0] irq;
    logic [NUM_SRC-1:0] emode;
    logic               claim;
    logic [ID_W-1:0]    claim_id;
    logic               complete;
    logic [ID_W-1:0]    complete_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] busy;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    plic_gateway #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .irq_src_i     (irq),
        .edge_mode_i   (emode),
        .claim_i       (claim),
        .claim_id_i    (claim_id),
        .complete_i    (complete),
        .complete_id_i (complete_id),
        .pending_o     (pending),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // h1..h3: the raw line as sampled 1, 2 and 3 edges ago.
    logic [NUM_SRC-1:0] h1, h2, h3;
    bit m_pend [NUM_SRC];
    bit m_busy [NUM_SRC];
    int m_cnt  [NUM_SRC];

    always @(posedge clk or negedge resetn) begin : model
        bit ev, clm, cpl;
        int inc, dec, cid, pid;
        if (!resetn) begin
            h1 = '0; h2 = '0; h3 = '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                m_pend[k] = 0; m_busy[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            cid = int'(claim_id);
            pid = int'(complete_id);
            for (int k = 0; k < NUM_SRC; k++) begin
                ev  = emode[k] && h2[k] && !h3[k];
                clm = claim    && cid >= 1 && cid <= NUM_SRC && cid - 1 == k;
                cpl = complete && pid >= 1 && pid <= NUM_SRC && pid - 1 == k;
                inc = 0;
                dec = 0;
                if (!m_pend[k] && !m_busy[k]) begin
                    if (!emode[k]) m_pend[k] = h2[k];
                    else if (ev) m_pend[k] = 1;
                    else if (m_cnt[k] > 0) begin m_pend[k] = 1; dec = 1; end
                end else if (m_pend[k]) begin
                    inc = int'(ev);
                    if (clm) begin m_pend[k] = 0; m_busy[k] = 1; end
                end else begin
                    inc = int'(ev);
                    if (cpl) begin
                        m_busy[k] = 0;
                        if (emode[k] && m_cnt[k] > 0) begin m_pend[k] = 1; dec = 1; end
                    end
                end
                m_cnt[k] = m_cnt[k] + inc - dec;
                if (m_cnt[k] > CMAX) m_cnt[k] = CMAX;
                if (!emode[k]) m_cnt[k] = 0;
            end
            h3 = h2; h2 = h1; h1 = irq;
        end
    end

    function automatic logic [NUM_SRC-1:0] pend_vec();
        logic [NUM_SRC-1:0] v;
        for (int k = 0; k < NUM_SRC; k++) v[k] = m_pend[k];
        return v;
    endfunction

    function automatic logic [NUM_SRC-1:0] busy_vec();
        logic [NUM_SRC-1:0] v;
        for (int k = 0; k < NUM_SRC; k++) v[k] = m_busy[k];
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pending", 32'(pending), 32'(pend_vec()));
            check("model_busy", 32'(busy), 32'(busy_vec()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; irq = '0; emode = '0;
        claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
        nxt(2);
        resetn = 1'b1;
        nxt(1);
    endtask

    task automatic pulse(input int k);
        irq[k] = 1'b1; nxt(1);
        irq[k] = 1'b0; nxt(1);
    endtask

    task automatic do_claim(input int id);
        claim = 1'b1; claim_id = ID_W'(id); nxt(1);
        claim = 1'b0; claim_id = '0;
    endtask

    task automatic do_complete(input int id);
        complete = 1'b1; complete_id = ID_W'(id); nxt(1);
        complete = 1'b0; complete_id = '0;
    endtask

    int n_repend;

    initial begin
        resetn = 1'b0; irq = '0; emode = '0;
        claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
        #1 cmp_en = 1'b1;

        // Level source: 3-edge latency, claim, complete with line still high.
        do_reset();
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        irq[0] = 1'b1;
        nxt(2);
        check("lvl_not_yet", 32'(pending), 32'h0);
        nxt(1);
        check("lvl_pend_edge3", 32'(pending), 32'h01);
        do_claim(1);
        check("lvl_claim_pend", 32'(pending), 32'h0);
        check("lvl_claim_busy", 32'(busy), 32'h01);
        do_complete(1);
        check("lvl_cpl_busy", 32'(busy), 32'h0);
        nxt(1);
        check("lvl_repend", 32'(pending), 32'h01);

        // Edge source: 4 pulses -> one pend plus 3 counted.
        do_reset();
        emode = 5'b00100;
        for (int i = 0; i < 4; i++) pulse(2);
        nxt(3);
        for (int i = 0; i < 4; i++) begin
            do_claim(3);
            check("edge_claimed", 32'(busy[2]), 32'h1);
            do_complete(3);
            check("edge_repend", 32'(pending[2]), (i < 3) ? 32'h1 : 32'h0);
        end

        // Saturation: 6 edges while claimed collapse to 3.
        do_reset();
        emode = 5'b00010;
        pulse(1);
        nxt(2);
        check("sat_pend", 32'(pending), 32'h02);
        do_claim(2);
        check("sat_busy", 32'(busy), 32'h02);
        repeat (6) pulse(1);
        nxt(3);
        n_repend = 0;
        for (int i = 0; i < 8; i++) begin
            do_complete(2);
            if (!pending[1]) break;
            n_repend++;
            do_claim(2);
        end
        check("sat_repend_count", 32'(n_repend), 32'd3);

        // Illegal IDs and completing a pending source change nothing.
        do_reset();
        irq = 5'b01001;
        nxt(3);
        check("ill_setup", 32'(pending), 32'h09);
        do_claim(0);
        check("ill_id0", {16'(pending), 16'(busy)}, {16'h09, 16'h0});
        do_claim(6);
        check("ill_id6", {16'(pending), 16'(busy)}, {16'h09, 16'h0});
        do_claim(7);
        check("ill_id7", {16'(pending), 16'(busy)}, {16'h09, 16'h0});
        do_complete(1);
        check("ill_cpl_pend", {16'(pending), 16'(busy)}, {16'h09, 16'h0});

        // Asynchronous reset while src4 is claimed with two counted edges.
        do_reset();
        emode = 5'b10000;
        pulse(4);
        nxt(2);
        do_claim(5);
        pulse(4);
        pulse(4);
        nxt(3);
        check("rst_pre_busy", 32'(busy), 32'h10);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_pend", 32'(pending), 32'h0);
        check("rst_async_busy", 32'(busy), 32'h0);
        nxt(1);
        resetn = 1'b1;
        nxt(6);
        check("rst_no_repend", {16'(pending), 16'(busy)}, 32'h0);

        // Simultaneous claim/complete of different IDs; edge in the decrement cycle.
        do_reset();
        irq[0] = 1'b1;
        nxt(3);
        do_claim(1);
        irq[0] = 1'b0;
        irq[1] = 1'b1;
        nxt(3);
        check("sim_setup", {16'(pending), 16'(busy)}, {16'h02, 16'h01});
        claim = 1'b1; claim_id = 3'd2; complete = 1'b1; complete_id = 3'd1;
        nxt(1);
        claim = 1'b0; complete = 1'b0;
        check("sim_both", {16'(pending), 16'(busy)}, {16'h00, 16'h02});
        emode[2] = 1'b1;
        pulse(2);
        nxt(2);
        do_claim(3);
        pulse(2);
        nxt(3);
        irq[2] = 1'b1;
        nxt(2);
        complete = 1'b1; complete_id = 3'd3;
        nxt(1);
        complete = 1'b0; irq[2] = 1'b0;
        check("dec_edge_repend", 32'(pending[2]), 32'h1);
        do_claim(3);
        do_complete(3);
        check("dec_edge_cnt_kept", 32'(pending[2]), 32'h1);
        do_claim(3);
        do_complete(3);
        check("dec_edge_drained", 32'(pending[2]), 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NUM_SRC; k++)
                if ($urandom_range(0, 7) == 0) irq[k] = ~irq[k];
            if ($urandom_range(0, 199) == 0) emode[$urandom_range(0, NUM_SRC - 1)] ^= 1'b1;
            claim       = ($urandom_range(0, 2) == 0);
            claim_id    = ID_W'($urandom_range(0, 7));
            complete    = ($urandom_range(0, 2) == 0);
            complete_id = ID_W'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) begin
                #2 resetn = 1'b0;
                nxt(1);
                resetn = 1'b1;
            end
            nxt(1);
        end
        claim = 1'b0; complete = 1'b0;
        nxt(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
